// File: rtl/pacman_pkg.sv
// Shared types and constants for Pac-Man motion and the colour mapper.
// The dir_t encoding doubles as the sprite-row select on flag.
package pacman_pkg;

    typedef enum logic [2:0] {
        RIGHT = 3'd0,
        LEFT  = 3'd1,
        UP    = 3'd2,
        DOWN  = 3'd3,
        STOP  = 3'd4
    } dir_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam logic [9:0] SPRITE_SIZE = 10'd15;
    localparam int         SCREEN_W    = 640;
    localparam int         SCREEN_H    = 480;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PLAN   = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_TEST   = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;

    // Unrecognised keys (including "no key") keep the previous request.
    function automatic dir_t key_to_dir(input logic [7:0] key, input dir_t keep);
        case (key)
            KEY_W:   return UP;
            KEY_A:   return LEFT;
            KEY_S:   return DOWN;
            KEY_D:   return RIGHT;
            default: return keep;
        endcase
    endfunction

endpackage

// File: rtl/pacman_frame_sync.sv
// Brings vsync into the Clk domain and emits a one-cycle pulse per rising edge.
module frame_edge_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/pacman_motion.sv
// Per-frame Pac-Man stepper: plans a one-step move, scans the maze ROM for
// walls along the leading edge, then commits or falls back to the current heading.
import pacman_pkg::*;

module pacman_motion #(
    parameter logic [9:0] START_X = 10'd320,
    parameter logic [9:0] START_Y = 10'd240,
    parameter logic [9:0] SIZE    = SPRITE_SIZE,
    parameter logic [9:0] STEP    = 10'd1,
    parameter logic [9:0] X_MAX   = 10'd639,
    parameter logic [9:0] Y_MAX   = 10'd479
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_clk,
    input  logic [7:0]          keycode,
    output logic [9:0]          map_addr,
    input  logic [SCREEN_W-1:0] map_data,
    output logic [9:0]          BallX,
    output logic [9:0]          BallY,
    output logic [9:0]          Ball_size,
    output logic [1:0]          flag,
    output logic                busy
);

    localparam logic signed [10:0] SZ   = {1'b0, SIZE};
    localparam logic signed [10:0] ST   = {1'b0, STEP};
    localparam logic signed [10:0] XMX  = {1'b0, X_MAX};
    localparam logic signed [10:0] YMX  = {1'b0, Y_MAX};
    localparam int                 SPAN = 2 * int'(SIZE) + 1;

    logic frame_edge;

    frame_edge_sync u_sync (
        .clk_i   (Clk),
        .rst_n_i (Reset),
        .async_i (frame_clk),
        .rise_o  (frame_edge)
    );

    logic [2:0] state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [9:0] row_q, row_d, addr_q, addr_d;
    logic [1:0] flag_q, flag_d;
    logic       force_q, force_d;
    dir_t       cur_q, cur_d, want_q, want_d, try_q, try_d;

    // Candidate geometry is derived from the committed position and try_q,
    // both stable for the whole check, so nothing needs to be latched.
    logic signed [10:0] nx, ny, lo_x, hi_x, lo_y, hi_y;
    logic               horiz, oob, hit;
    logic [9:0]         first_row, lead_col;
    logic [SCREEN_W-1:0] span_bits, span_mask;

    always_comb begin
        nx = {1'b0, x_q};
        ny = {1'b0, y_q};
        case (try_q)
            RIGHT:   nx = nx + ST;
            LEFT:    nx = nx - ST;
            UP:      ny = ny - ST;
            DOWN:    ny = ny + ST;
            default: ;
        endcase
        lo_x = nx - SZ;
        hi_x = nx + SZ;
        lo_y = ny - SZ;
        hi_y = ny + SZ;
        oob  = (lo_x < 11'sd0) || (hi_x > XMX) || (lo_y < 11'sd0) || (hi_y > YMX);
        horiz     = (try_q == RIGHT) || (try_q == LEFT);
        first_row = (try_q == DOWN) ? hi_y[9:0] : lo_y[9:0];
        lead_col  = (try_q == RIGHT) ? hi_x[9:0] : lo_x[9:0];
        span_mask = ~({SCREEN_W{1'b1}} << SPAN);
        span_bits = (map_data >> lo_x[9:0]) & span_mask;
        hit       = horiz ? map_data[lead_col] : |span_bits;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        row_d   = row_q;
        addr_d  = addr_q;
        flag_d  = flag_q;
        force_d = force_q;
        cur_d   = cur_q;
        want_d  = want_q;
        try_d   = try_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_edge) begin
                    want_d  = key_to_dir(keycode, want_q);
                    force_d = 1'b0;
                    if (want_d != STOP) begin
                        try_d   = want_d;
                        state_d = ST_PLAN;
                    end else if (cur_q != STOP) begin
                        try_d   = cur_q;
                        state_d = ST_PLAN;
                    end
                end
            end
            ST_PLAN: begin
                if (oob) begin
                    force_d = 1'b1;
                    state_d = ST_TEST;
                end else begin
                    row_d   = first_row;
                    addr_d  = first_row;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_TEST;
            ST_TEST: begin
                if (force_q || hit) begin
                    // Blocked request falls back to the current heading once;
                    // want_q is kept so the turn is retried on later frames.
                    if (try_q != cur_q && cur_q != STOP) begin
                        try_d   = cur_q;
                        force_d = 1'b0;
                        state_d = ST_PLAN;
                    end else begin
                        cur_d   = STOP;
                        state_d = ST_IDLE;
                    end
                end else if (horiz && row_q != hi_y[9:0]) begin
                    row_d   = row_q + 10'd1;
                    addr_d  = row_q + 10'd1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                x_d     = nx[9:0];
                y_d     = ny[9:0];
                cur_d   = try_q;
                flag_d  = try_q[1:0];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            x_q     <= START_X;
            y_q     <= START_Y;
            row_q   <= 10'd0;
            addr_q  <= 10'd0;
            flag_q  <= 2'd0;
            force_q <= 1'b0;
            cur_q   <= STOP;
            want_q  <= STOP;
            try_q   <= STOP;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            flag_q  <= flag_d;
            force_q <= force_d;
            cur_q   <= cur_d;
            want_q  <= want_d;
            try_q   <= try_d;
        end
    end

    assign map_addr  = addr_q;
    assign BallX     = x_q;
    assign BallY     = y_q;
    assign Ball_size = SIZE;
    assign flag      = flag_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion with a registered maze ROM model.
module tb_pacman_motion;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         frame_clk = 1'b0;
    logic [7:0]   keycode = 8'h00;
    logic [9:0]   map_addr;
    logic [639:0] map_data;
    logic [9:0]   BallX, BallY, Ball_size;
    logic [1:0]   flag;
    logic         busy;

    logic [639:0] rom [0:479];
    int           total = 0;
    int           bad = 0;
    int           busy_cnt = 0;
    int           b0;

    pacman_motion dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .map_addr  (map_addr),
        .map_data  (map_data),
        .BallX     (BallX),
        .BallY     (BallY),
        .Ball_size (Ball_size),
        .flag      (flag),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) map_data <= (map_addr < 10'd480) ? rom[map_addr] : '0;

    always @(negedge Clk) if (busy === 1'b1) busy_cnt <= busy_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raise vsync, let the move run to completion (bounded), drop vsync.
    task automatic frame_edge();
        int n;
        @(negedge Clk) frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(negedge Clk);
            n++;
        end
        chk("move_done", {31'd0, busy}, 32'd0);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        for (int r = 0; r < 480; r++) rom[r] = '0;

        // Reset with vsync toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk) frame_clk = ~frame_clk;
        end
        @(negedge Clk) frame_clk = 1'b0;
        chk("rst_x", BallX, 320);
        chk("rst_y", BallY, 240);
        chk("rst_flag", flag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", map_addr, 0);
        chk("size", Ball_size, 15);
        Reset = 1'b1;
        keycode = 8'h07;
        repeat (10) @(negedge Clk);
        chk("no_edge_x", BallX, 320);
        chk("no_edge_busy", busy, 0);

        // Open map, right x5
        for (int i = 1; i <= 5; i++) begin
            b0 = busy_cnt;
            frame_edge();
            chk("right_x", BallX, 320 + i);
            chk("right_y", BallY, 240);
            chk("right_flag", flag, 0);
            chk("right_cycles", busy_cnt - b0, 64);
        end

        // Open map, up once
        do_reset();
        keycode = 8'h1A;
        b0 = busy_cnt;
        frame_edge();
        chk("up_y", BallY, 239);
        chk("up_x", BallX, 320);
        chk("up_flag", flag, 2);
        chk("up_addr", map_addr, 224);
        chk("up_cycles", busy_cnt - b0, 4);

        // Wall at (row 250, col 336) blocks the first rightward move
        do_reset();
        rom[250][336] = 1'b1;
        keycode = 8'h07;
        b0 = busy_cnt;
        frame_edge();
        chk("wall_x", BallX, 320);
        chk("wall_flag", flag, 0);
        chk("wall_addr", map_addr, 250);
        chk("wall_cycles", busy_cnt - b0, 53);
        rom[250][336] = 1'b0;

        // Corridor: up blocked at cols 305/306 of row 224, gap reached at X=322
        do_reset();
        rom[224][305] = 1'b1;
        rom[224][306] = 1'b1;
        keycode = 8'h07;
        frame_edge();
        chk("cor_x1", BallX, 321);
        keycode = 8'h1A;
        b0 = busy_cnt;
        frame_edge();
        chk("cor_x2", BallX, 322);
        chk("cor_y2", BallY, 240);
        chk("cor_flag2", flag, 0);
        chk("cor_cycles2", busy_cnt - b0, 67);
        keycode = 8'h00;
        frame_edge();
        chk("cor_x3", BallX, 322);
        chk("cor_y3", BallY, 239);
        chk("cor_flag3", flag, 2);
        rom[224][305] = 1'b0;
        rom[224][306] = 1'b0;

        // Left to the screen edge, then a bounds failure with no map read
        do_reset();
        keycode = 8'h04;
        for (int i = 0; i < 305; i++) frame_edge();
        chk("left_x", BallX, 15);
        chk("left_flag", flag, 1);
        chk("left_addr", map_addr, 255);
        b0 = busy_cnt;
        frame_edge();
        chk("bound_x", BallX, 15);
        chk("bound_y", BallY, 240);
        chk("bound_flag", flag, 1);
        chk("bound_addr", map_addr, 255);
        chk("bound_cycles", busy_cnt - b0, 2);

        // Reset in the middle of a row scan aborts the move
        keycode = 8'h07;
        @(negedge Clk) frame_clk = 1'b1;
        repeat (10) @(negedge Clk);
        chk("mid_busy", busy, 1);
        Reset = 1'b0;
        frame_clk = 1'b0;
        @(negedge Clk);
        chk("mid_rst_x", BallX, 320);
        chk("mid_rst_y", BallY, 240);
        chk("mid_rst_flag", flag, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", map_addr, 0);
        Reset = 1'b1;
        repeat (10) @(negedge Clk);
        chk("post_rst_x", BallX, 320);
        chk("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
